// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
// Optional parity support is selected by the SIPO_PARITY_EN macro.
package sipo_pkg;

    localparam int unsigned SIPO_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PAR
    } sipo_state_e;

    // Even parity over data plus parity bit: 1 means the group has odd weight.
    function automatic logic even_par(input logic [SIPO_MAX_WIDTH:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register for completed words.
// A word arriving while the entry is full and not draining is dropped and flagged.
module sipo_hold_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             perr,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             can_load;

    // Draining and reloading in the same cycle avoids a bubble.
    assign can_load = !valid_q || ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (load) begin
            if (can_load) begin
                data_d  = load_data;
                valid_d = 1'b1;
                perr_d  = load_perr;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign perr    = perr_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel receiver with a 1-entry output holding register.
// Define SIPO_PARITY_EN to expect an even-parity bit after each word.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             parity_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    sipo_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] bit_mask;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    // Bits are placed by position; the register is cleared on every start bit.
    assign bit_mask = {{(WIDTH-1){1'b0}}, sin} << cnt_q;

`ifdef SIPO_PARITY_EN
    logic [SIPO_MAX_WIDTH:0] par_vec;

    always_comb begin
        par_vec            = '0;
        par_vec[WIDTH:0]   = {sin, sr_q};
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        word      = sr_q;
        word_perr = 1'b0;
        if (sin_valid) begin
            if (sin_start) begin
                // Start bit always begins a fresh word, including a resync mid-word.
                state_d = RECV;
                cnt_d   = CntW'(1);
                sr_d    = {{(WIDTH-1){1'b0}}, sin};
            end else begin
                unique case (state_q)
                    RECV: begin
                        sr_d = sr_q | bit_mask;
                        if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                            state_d = PAR;
                            cnt_d   = CntW'(WIDTH);
`else
                            state_d   = IDLE;
                            cnt_d     = '0;
                            word_done = 1'b1;
                            word      = sr_d;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PAR: begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        word_done = 1'b1;
                        word      = sr_q;
                        word_perr = even_par(par_vec);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (word_done),
        .load_data (word),
        .load_perr (word_perr),
        .ready     (pout_ready),
        .ovr_clr   (ovr_clr),
        .data      (pout),
        .valid     (pout_valid),
        .perr      (parity_err),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4); directed scenarios plus random traffic.
// Honours SIPO_PARITY_EN the same way as the design.
module tb_sipo_deser;

    localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_start = 1'b0;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready = 1'b0;
    logic             overrun;
    logic             ovr_clr = 1'b0;
    logic             parity_err;

    int errors = 0;
    int checks = 0;

    // Reference model: bits of the word in progress, plus the holding entry.
    logic             mq[$];
    logic             m_in = 1'b0;
    logic [WIDTH-1:0] m_word = '0;
    logic             m_valid = 1'b0;
    logic             m_ovr = 1'b0;
    logic             m_perr = 1'b0;

    sipo_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_start  (sin_start),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .parity_err (parity_err)
    );

    initial forever #5 clk = ~clk;

    task automatic model_edge();
        logic             done;
        logic             p;
        logic             set;
        logic [WIDTH-1:0] w;
        done = 1'b0;
        set  = 1'b0;
        p    = 1'b0;
        w    = '0;
        if (!rst_n) begin
            m_in = 1'b0;
            mq.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
            return;
        end
        if (sin_valid) begin
            if (sin_start) begin
                m_in = 1'b1;
                mq.delete();
                mq.push_back(sin);
            end else if (m_in) begin
                mq.push_back(sin);
            end
            if (m_in && mq.size() == WIDTH + PB) begin
                for (int i = 0; i < WIDTH; i++) w[i] = mq[i];
                if (PB == 1) foreach (mq[i]) p = p ^ mq[i];
                done = 1'b1;
                m_in = 1'b0;
                mq.delete();
            end
        end
        if (done) begin
            if (!m_valid || pout_ready) begin
                m_word  = w;
                m_valid = 1'b1;
                m_perr  = p;
            end else begin
                set = 1'b1;
            end
        end else if (m_valid && pout_ready) begin
            m_valid = 1'b0;
        end
        if (set) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic b, input logic st, input logic rdy,
                       input logic clr);
        sin_valid  = v;
        sin        = b;
        sin_start  = st;
        pout_ready = rdy;
        ovr_clr    = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Sends one word LSB first; in parity builds a correct parity bit follows.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input logic rdy,
                             input logic rdy_last);
        int   n;
        logic b;
        logic last;
        n = WIDTH + PB;
        for (int i = 0; i < n; i++) begin
            b    = (i < WIDTH) ? w[i] : ^w;
            last = (i == n - 1);
            cyc(1'b1, b, i == 0, last ? rdy_last : rdy, 1'b0);
            if (!last) repeat (gap) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (pout !== 4'h0) begin errors++; $display("FAIL reset_pout: got %h want 0", pout); end
        checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_basic();
        send_word(4'hD, 0, 1'b1, 1'b1);
        checks++; if (pout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", pout_valid); end
        checks++; if (pout !== 4'hD) begin errors++; $display("FAIL basic_pout: got %h want d", pout); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b want 0", pout_valid); end
        checks++; if (pout !== 4'hD) begin errors++; $display("FAIL basic_hold: got %h want d", pout); end
    endtask

    task automatic test_gaps();
        send_word(4'h0, 0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'hD, 3, 1'b1, 1'b1);
        checks++; if (pout_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b want 1", pout_valid); end
        checks++; if (pout !== 4'hD) begin errors++; $display("FAIL gaps_pout: got %h want d", pout); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        send_word(4'hA, 0, 1'b0, 1'b0);
        send_word(4'h5, 0, 1'b0, 1'b0);
        checks++; if (pout !== 4'hA) begin errors++; $display("FAIL ovr_pout: got %h want a", pout); end
        checks++; if (pout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", pout_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b want 0", pout_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        send_word(4'h3, 0, 1'b0, 1'b0);
        checks++; if (pout !== 4'h3) begin errors++; $display("FAIL b2b_first: got %h want 3", pout); end
        send_word(4'hC, 0, 1'b0, 1'b1);
        checks++; if (pout !== 4'hC) begin errors++; $display("FAIL b2b_pout: got %h want c", pout); end
        checks++; if (pout_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", pout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b want 0", overrun); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_resync_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(4'h8, 0, 1'b1, 1'b1);
        checks++; if (pout !== 4'h8) begin errors++; $display("FAIL resync_pout: got %h want 8", pout); end
        checks++; if (pout_valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b want 1", pout_valid); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'h6, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (pout !== 4'h0) begin errors++; $display("FAIL rst_pout: got %h want 0", pout); end
        checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pout_valid); end
        rst_n = 1'b1;
        send_word(4'h9, 0, 1'b1, 1'b1);
        checks++; if (pout !== 4'h9) begin errors++; $display("FAIL rst_next: got %h want 9", pout); end
        checks++; if (pout_valid !== 1'b1) begin errors++; $display("FAIL rst_next_valid: got %b want 1", pout_valid); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        logic [4:0] good;
        logic [4:0] bad;
        good = 5'b11011;
        bad  = 5'b01011;
        for (int i = 0; i < 5; i++) cyc(1'b1, good[i], i == 0, 1'b1, 1'b0);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good: got %b want 0", parity_err); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, bad[i], i == 0, 1'b1, 1'b0);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %b want 1", parity_err); end
        checks++; if (pout !== 4'hB) begin errors++; $display("FAIL par_pout: got %h want b", pout); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 5) == 0,
                1'($urandom), $urandom_range(0, 9) == 0);
            checks++; if (pout !== m_word) begin errors++; $display("FAIL rnd_pout@%0d: got %h want %h", n, pout, m_word); end
            checks++; if (pout_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, pout_valid, m_valid); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr@%0d: got %b want %b", n, overrun, m_ovr); end
            checks++; if (parity_err !== m_perr) begin errors++; $display("FAIL rnd_perr@%0d: got %b want %b", n, parity_err, m_perr); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_resync_reset();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
